// File: rtl/reservation_station.sv
// reservation_station: Tomasulo reservation station for integer and branch ops.
// Holds up to RS_SIZE issued instructions and wakes pending operands from
// two result buses (ALU and LSB). Each cycle it sends at most one fully-ready
// entry to the combinational ALU through a registered interface.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (0 = stall), flush_in (mispredict)
//   issue_*        : new instruction with operand values or producer ROB tags
//   alu_cdb_*      : ALU result broadcast (valid / tag / value)
//   lsb_cdb_*      : LSB result broadcast (valid / tag / value)
//   rs_full        : combinational, every entry busy
//   alu_*          : registered dispatch to the ALU; alu_opt == 0 means idle
module reservation_station #(
    parameter int RS_SIZE  = 8,
    parameter int RS_IDX_W = 3,
    parameter int OPT_W    = 6,
    parameter int ROB_W    = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              issue_valid,
    input  logic [OPT_W-1:0]  issue_opt,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic              issue_qj_busy,
    input  logic [ROB_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic              issue_qk_busy,
    input  logic [ROB_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_pc,
    input  logic [ROB_W-1:0]  issue_rob,
    input  logic              alu_cdb_valid,
    input  logic [ROB_W-1:0]  alu_cdb_rob,
    input  logic [DATA_W-1:0] alu_cdb_val,
    input  logic              lsb_cdb_valid,
    input  logic [ROB_W-1:0]  lsb_cdb_rob,
    input  logic [DATA_W-1:0] lsb_cdb_val,
    output logic              rs_full,
    output logic [OPT_W-1:0]  alu_opt,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [DATA_W-1:0] alu_imm,
    output logic [DATA_W-1:0] alu_pc,
    output logic [ROB_W-1:0]  alu_rob
);

    // Entry storage
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
    logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
    logic [OPT_W-1:0]   opt_q [RS_SIZE];
    logic [OPT_W-1:0]   opt_d [RS_SIZE];
    logic [DATA_W-1:0]  vj_q  [RS_SIZE];
    logic [DATA_W-1:0]  vj_d  [RS_SIZE];
    logic [DATA_W-1:0]  vk_q  [RS_SIZE];
    logic [DATA_W-1:0]  vk_d  [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qj_d  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_d  [RS_SIZE];
    logic [DATA_W-1:0]  imm_q [RS_SIZE];
    logic [DATA_W-1:0]  imm_d [RS_SIZE];
    logic [DATA_W-1:0]  pc_q  [RS_SIZE];
    logic [DATA_W-1:0]  pc_d  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_d [RS_SIZE];

    // Dispatch registers
    logic [OPT_W-1:0]  alu_opt_q, alu_opt_d;
    logic [DATA_W-1:0] alu_rs1_q, alu_rs1_d;
    logic [DATA_W-1:0] alu_rs2_q, alu_rs2_d;
    logic [DATA_W-1:0] alu_imm_q, alu_imm_d;
    logic [DATA_W-1:0] alu_pc_q,  alu_pc_d;
    logic [ROB_W-1:0]  alu_rob_q, alu_rob_d;

    logic [RS_SIZE-1:0]  ready_s;
    logic                disp_found_s;
    logic [RS_IDX_W-1:0] disp_idx_s;
    logic [RS_IDX_W-1:0] free_idx_s;
    logic                issue_en_s;

    // Resolve one operand against both result buses; returns {still_pending, value}.
    // The ALU bus is checked first so it wins on a (disallowed) duplicate tag.
    function automatic logic [DATA_W:0] capture_operand(
        input logic              pending,
        input logic [ROB_W-1:0]  tag,
        input logic [DATA_W-1:0] val,
        input logic              a_valid,
        input logic [ROB_W-1:0]  a_tag,
        input logic [DATA_W-1:0] a_val,
        input logic              l_valid,
        input logic [ROB_W-1:0]  l_tag,
        input logic [DATA_W-1:0] l_val
    );
        logic [DATA_W:0] res;
        if (pending && a_valid && (a_tag == tag)) begin
            res = {1'b0, a_val};
        end else if (pending && l_valid && (l_tag == tag)) begin
            res = {1'b0, l_val};
        end else begin
            res = {pending, val};
        end
        return res;
    endfunction

    // Ready vector, lowest ready entry, lowest free entry and full flag (pre-edge state)
    always_comb begin
        ready_s      = busy_q & ~qj_busy_q & ~qk_busy_q;
        disp_found_s = |ready_s;
        disp_idx_s   = {RS_IDX_W{1'b0}};
        free_idx_s   = {RS_IDX_W{1'b0}};
        // Scan downward so the lowest matching index is the last one written.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            disp_idx_s = ready_s[i] ? RS_IDX_W'(i) : disp_idx_s;
            free_idx_s = busy_q[i]  ? free_idx_s   : RS_IDX_W'(i);
        end
        rs_full    = &busy_q;
        issue_en_s = issue_valid & ~rs_full;
    end

    // Next state of every entry: flush, stall, issue with bypass, wakeup, dispatch release
    always_comb begin
        busy_d    = busy_q;
        qj_busy_d = qj_busy_q;
        qk_busy_d = qk_busy_q;
        opt_d     = opt_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        rob_d     = rob_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (flush_in) begin
                busy_d[i] = 1'b0;
            end else if (!rdy_in) begin
                busy_d[i] = busy_q[i];
            end else if (issue_en_s && (free_idx_s == RS_IDX_W'(i))) begin
                busy_d[i] = 1'b1;
                opt_d[i]  = issue_opt;
                {qj_busy_d[i], vj_d[i]} = capture_operand(issue_qj_busy, issue_qj, issue_vj,
                    alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                {qk_busy_d[i], vk_d[i]} = capture_operand(issue_qk_busy, issue_qk, issue_vk,
                    alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                qj_d[i]   = issue_qj;
                qk_d[i]   = issue_qk;
                imm_d[i]  = issue_imm;
                pc_d[i]   = issue_pc;
                rob_d[i]  = issue_rob;
            end else if (busy_q[i]) begin
                {qj_busy_d[i], vj_d[i]} = capture_operand(qj_busy_q[i], qj_q[i], vj_q[i],
                    alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                {qk_busy_d[i], vk_d[i]} = capture_operand(qk_busy_q[i], qk_q[i], vk_q[i],
                    alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                busy_d[i] = ~(disp_found_s && (disp_idx_s == RS_IDX_W'(i)));
            end else begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Dispatch register next state: copy the lowest ready entry, otherwise idle and hold operands
    always_comb begin
        alu_opt_d = alu_opt_q;
        alu_rs1_d = alu_rs1_q;
        alu_rs2_d = alu_rs2_q;
        alu_imm_d = alu_imm_q;
        alu_pc_d  = alu_pc_q;
        alu_rob_d = alu_rob_q;
        if (flush_in || !rdy_in || !disp_found_s) begin
            alu_opt_d = {OPT_W{1'b0}};
        end else begin
            alu_opt_d = opt_q[disp_idx_s];
            alu_rs1_d = vj_q[disp_idx_s];
            alu_rs2_d = vk_q[disp_idx_s];
            alu_imm_d = imm_q[disp_idx_s];
            alu_pc_d  = pc_q[disp_idx_s];
            alu_rob_d = rob_q[disp_idx_s];
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q    <= {RS_SIZE{1'b0}};
            qj_busy_q <= {RS_SIZE{1'b0}};
            qk_busy_q <= {RS_SIZE{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                opt_q[i] <= {OPT_W{1'b0}};
                vj_q[i]  <= {DATA_W{1'b0}};
                vk_q[i]  <= {DATA_W{1'b0}};
                qj_q[i]  <= {ROB_W{1'b0}};
                qk_q[i]  <= {ROB_W{1'b0}};
                imm_q[i] <= {DATA_W{1'b0}};
                pc_q[i]  <= {DATA_W{1'b0}};
                rob_q[i] <= {ROB_W{1'b0}};
            end
            alu_opt_q <= {OPT_W{1'b0}};
            alu_rs1_q <= {DATA_W{1'b0}};
            alu_rs2_q <= {DATA_W{1'b0}};
            alu_imm_q <= {DATA_W{1'b0}};
            alu_pc_q  <= {DATA_W{1'b0}};
            alu_rob_q <= {ROB_W{1'b0}};
        end else begin
            busy_q    <= busy_d;
            qj_busy_q <= qj_busy_d;
            qk_busy_q <= qk_busy_d;
            opt_q     <= opt_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            rob_q     <= rob_d;
            alu_opt_q <= alu_opt_d;
            alu_rs1_q <= alu_rs1_d;
            alu_rs2_q <= alu_rs2_d;
            alu_imm_q <= alu_imm_d;
            alu_pc_q  <= alu_pc_d;
            alu_rob_q <= alu_rob_d;
        end
    end

    assign alu_opt = alu_opt_q;
    assign alu_rs1 = alu_rs1_q;
    assign alu_rs2 = alu_rs2_q;
    assign alu_imm = alu_imm_q;
    assign alu_pc  = alu_pc_q;
    assign alu_rob = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed stimulus, a behavioural model
// updated on every rising edge, a negedge compare process against the model,
// and literal expectations at key points of each scenario.
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        issue_valid;
    logic [5:0]  issue_opt;
    logic [31:0] issue_vj, issue_vk, issue_imm, issue_pc;
    logic        issue_qj_busy, issue_qk_busy;
    logic [3:0]  issue_qj, issue_qk, issue_rob;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_rob, lsb_cdb_rob;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic        rs_full;
    logic [5:0]  alu_opt;
    logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_pc;
    logic [3:0]  alu_rob;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid(issue_valid), .issue_opt(issue_opt),
        .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
        .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob(issue_rob),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
        .rs_full(rs_full), .alu_opt(alu_opt), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob(alu_rob)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        busy;
        logic [5:0]  opt;
        logic [31:0] vj;
        logic        qjb;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic        qkb;
        logic [3:0]  qk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } ent_t;

    ent_t        m [8];
    logic [5:0]  m_opt = 6'd0;
    logic [31:0] m_rs1 = 32'd0, m_rs2 = 32'd0, m_imm = 32'd0, m_pc = 32'd0;
    logic [3:0]  m_rob = 4'd0;

    // {still_waiting, value} for an operand seen against this cycle's buses
    function automatic logic [32:0] resolve(input logic pend, input logic [3:0] tag, input logic [31:0] v);
        if (pend && alu_cdb_valid && alu_cdb_rob == tag) return {1'b0, alu_cdb_val};
        if (pend && lsb_cdb_valid && lsb_cdb_rob == tag) return {1'b0, lsb_cdb_val};
        return {pend, v};
    endfunction

    function automatic logic model_full();
        for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        ent_t nxt [8];
        int disp = -1;
        int slot = -1;
        logic [32:0] r;
        if (!rst_in) begin
            for (int i = 0; i < 8; i++) m[i] = '0;
            m_opt = 6'd0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_imm = 32'd0; m_pc = 32'd0; m_rob = 4'd0;
        end else if (flush_in) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            m_opt = 6'd0;
        end else if (!rdy_in) begin
            m_opt = 6'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (disp < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) disp = i;
                if (slot < 0 && !m[i].busy) slot = i;
            end
            nxt = m;
            for (int i = 0; i < 8; i++) begin
                if (m[i].busy) begin
                    r = resolve(m[i].qjb, m[i].qj, m[i].vj); nxt[i].qjb = r[32]; nxt[i].vj = r[31:0];
                    r = resolve(m[i].qkb, m[i].qk, m[i].vk); nxt[i].qkb = r[32]; nxt[i].vk = r[31:0];
                end
            end
            if (disp >= 0) begin
                m_opt = m[disp].opt; m_rs1 = m[disp].vj; m_rs2 = m[disp].vk;
                m_imm = m[disp].imm; m_pc = m[disp].pc; m_rob = m[disp].rob;
                nxt[disp].busy = 1'b0;
            end else begin
                m_opt = 6'd0;
            end
            if (issue_valid && slot >= 0) begin
                nxt[slot].busy = 1'b1;
                nxt[slot].opt  = issue_opt;
                r = resolve(issue_qj_busy, issue_qj, issue_vj); nxt[slot].qjb = r[32]; nxt[slot].vj = r[31:0];
                r = resolve(issue_qk_busy, issue_qk, issue_vk); nxt[slot].qkb = r[32]; nxt[slot].vk = r[31:0];
                nxt[slot].qj  = issue_qj;
                nxt[slot].qk  = issue_qk;
                nxt[slot].imm = issue_imm;
                nxt[slot].pc  = issue_pc;
                nxt[slot].rob = issue_rob;
            end
            m = nxt;
        end
    endtask

    always @(posedge clk_in) model_step();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, away from the rising edge
    always @(negedge clk_in) begin
        if (chk_en) begin
            check("model rs_full", {31'd0, rs_full}, {31'd0, model_full()});
            check("model alu_opt", {26'd0, alu_opt}, {26'd0, m_opt});
            check("model alu_rs1", alu_rs1, m_rs1);
            check("model alu_rs2", alu_rs2, m_rs2);
            check("model alu_imm", alu_imm, m_imm);
            check("model alu_pc",  alu_pc,  m_pc);
            check("model alu_rob", {28'd0, alu_rob}, {28'd0, m_rob});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_opt = 6'd0; issue_vj = 32'd0; issue_vk = 32'd0;
        issue_qj_busy = 1'b0; issue_qk_busy = 1'b0; issue_qj = 4'd0; issue_qk = 4'd0;
        issue_imm = 32'd0; issue_pc = 32'd0; issue_rob = 4'd0;
        alu_cdb_valid = 1'b0; alu_cdb_rob = 4'd0; alu_cdb_val = 32'd0;
        lsb_cdb_valid = 1'b0; lsb_cdb_rob = 4'd0; lsb_cdb_val = 32'd0;
        flush_in = 1'b0;
    endtask

    task automatic set_issue(input logic [5:0] opt, input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                             input logic [31:0] vk, input logic qkb, input logic [3:0] qk,
                             input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        issue_valid = 1'b1; issue_opt = opt; issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj;
        issue_vk = vk; issue_qk_busy = qkb; issue_qk = qk; issue_imm = imm; issue_pc = pc; issue_rob = rob;
    endtask

    task automatic alu_bcast(input logic [3:0] tag, input logic [31:0] val);
        alu_cdb_valid = 1'b1; alu_cdb_rob = tag; alu_cdb_val = val;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_in = 1'b0; rdy_in = 1'b1;
        idle();
        cyc(); cyc();
        chk_en = 1'b1;
        check("reset alu_opt", {26'd0, alu_opt}, 32'd0);
        check("reset rs_full", {31'd0, rs_full}, 32'd0);
        rst_in = 1'b1;
        cyc();

        // ADDI, no dependencies: dispatched after the next edge
        set_issue(6'd3, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd3, 32'h100, 4'd2);
        cyc(); idle();
        check("addi not yet", {26'd0, alu_opt}, 32'd0);
        cyc();
        check("addi opt", {26'd0, alu_opt}, 32'd3);
        check("addi rs1", alu_rs1, 32'd5);
        check("addi imm", alu_imm, 32'd3);
        check("addi rob", {28'd0, alu_rob}, 32'd2);
        cyc();
        check("addi idle after", {26'd0, alu_opt}, 32'd0);

        // ADD waiting on tag 4, woken by ALU bus, eligible only the edge after
        set_issue(6'd1, 32'd0, 1'b1, 4'd4, 32'd7, 1'b0, 4'd0, 32'd0, 32'h104, 4'd3);
        cyc(); idle();
        cyc();
        check("add waits", {26'd0, alu_opt}, 32'd0);
        alu_bcast(4'd4, 32'd10);
        cyc(); idle();
        check("add woken not dispatched", {26'd0, alu_opt}, 32'd0);
        cyc();
        check("add opt", {26'd0, alu_opt}, 32'd1);
        check("add rs1", alu_rs1, 32'd10);
        check("add rs2", alu_rs2, 32'd7);

        // Same-cycle bypass from the LSB bus
        set_issue(6'd2, 32'd0, 1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 32'd0, 32'h108, 4'd5);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd6; lsb_cdb_val = 32'h55;
        cyc(); idle();
        cyc();
        check("bypass opt", {26'd0, alu_opt}, 32'd2);
        check("bypass rs1", alu_rs1, 32'h55);

        // Fill all 8 entries waiting on tag 1; 9th issue dropped
        for (int i = 0; i < 8; i++) begin
            set_issue(6'd4, 32'd0, 1'b1, 4'd1, i, 1'b0, 4'd0, 32'd0, 32'h200 + i, 4'(i));
            cyc();
        end
        idle();
        check("full", {31'd0, rs_full}, 32'd1);
        set_issue(6'd5, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd0, 32'h300, 4'd9);
        cyc(); idle();
        check("full after drop", {31'd0, rs_full}, 32'd1);
        alu_bcast(4'd1, 32'h100);
        cyc(); idle();
        check("full woken idle", {26'd0, alu_opt}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("drain opt", {26'd0, alu_opt}, 32'd4);
            check("drain order", alu_rs2, k);
            check("drain rs1", alu_rs1, 32'h100);
            check("drain not full", {31'd0, rs_full}, 32'd0);
        end
        cyc();
        check("dropped issue absent", {26'd0, alu_opt}, 32'd0);

        // Flush with 3 waiting entries
        for (int i = 0; i < 3; i++) begin
            set_issue(6'd6, 32'd0, 1'b1, 4'd7, 32'd1, 1'b0, 4'd0, 32'd0, 32'h400, 4'(10 + i));
            cyc();
        end
        idle();
        flush_in = 1'b1;
        cyc(); idle();
        check("flush opt", {26'd0, alu_opt}, 32'd0);
        check("flush not full", {31'd0, rs_full}, 32'd0);
        alu_bcast(4'd7, 32'd1);
        cyc(); idle();
        cyc();
        check("flushed no dispatch", {26'd0, alu_opt}, 32'd0);

        // Reset mid-operation clears entries and all dispatch outputs
        set_issue(6'd7, 32'h11, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0, 32'h33, 32'h44, 4'd6);
        cyc();
        set_issue(6'd7, 32'd0, 1'b1, 4'd8, 32'd1, 1'b0, 4'd0, 32'd0, 32'h48, 4'd7);
        cyc(); idle();
        check("pre-reset opt", {26'd0, alu_opt}, 32'd7);
        rst_in = 1'b0;
        cyc();
        rst_in = 1'b1;
        check("mid reset opt", {26'd0, alu_opt}, 32'd0);
        check("mid reset rs1", alu_rs1, 32'd0);
        check("mid reset imm", alu_imm, 32'd0);
        check("mid reset pc", alu_pc, 32'd0);
        alu_bcast(4'd8, 32'd5);
        cyc(); idle();
        cyc();
        check("reset no dispatch", {26'd0, alu_opt}, 32'd0);

        // Stall with a ready entry for 3 cycles
        set_issue(6'd8, 32'hA, 1'b0, 4'd0, 32'hB, 1'b0, 4'd0, 32'hC, 32'h40, 4'd13);
        cyc(); idle();
        rdy_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cyc();
            check("stall opt", {26'd0, alu_opt}, 32'd0);
        end
        rdy_in = 1'b1;
        cyc();
        check("post-stall opt", {26'd0, alu_opt}, 32'd8);
        check("post-stall rs1", alu_rs1, 32'hA);
        check("post-stall rs2", alu_rs2, 32'hB);
        check("post-stall pc", alu_pc, 32'h40);
        check("post-stall rob", {28'd0, alu_rob}, 32'd13);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
